ps2_scancode_decoder: RTL
=========================

# ps2_scancode_decoder

Consumes the raw byte stream from `PS2_Controller` (`received_data` / `received_data_en`) and decodes PS/2 Set-2 make/break sequences, including `E0` extended and `F0` break prefixes. It produces one registered event per complete key code and tracks press/release state for the accelerate and brake keys. Its `accel` output replaces the "last byte received" latch in the top level: `accel` deasserts when the key is released instead of staying latched until the next key arrives. It sits between `PS2_Controller` and the vehicle-control logic.

## Interface
- `ACCEL_CODE`, default 8'h73: non-extended scan code of the accelerate key.
- `BRAKE_CODE`, default 8'h72: non-extended scan code of the brake key.
- `TIMEOUT_CYCLES`, default 50000: idle cycles allowed after a prefix byte before the sequence is abandoned (1 ms at 50 MHz).
- `CLOCK_50`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `received_data`  in  8  byte from `PS2_Controller`; valid only when `received_data_en`=1.
- `received_data_en`  in  1  one-cycle strobe, one per received byte.
- `key_event`  out  1  one-cycle pulse when a complete make or break code is decoded.
- `key_code`  out  8  final (non-prefix) byte of the last decoded code; holds between events.
- `key_extended`  out  1  last decoded code was `E0`-prefixed; holds between events.
- `key_release`  out  1  last decoded code was a break (`F0`); holds between events.
- `accel_held`  out  1  accelerate key currently pressed.
- `brake_held`  out  1  brake key currently pressed.
- `accel`  out  2  2'b10 when only accelerate is held; 2'b01 when only brake is held; 2'b00 otherwise.
- `seq_error`  out  1  one-cycle pulse when a sequence is malformed or times out.

## Operation
- FSM states: `S_IDLE`, `S_E0`, `S_F0`, `S_E0F0`. A state advances only on a cycle with `received_data_en`=1, except for the timeout.
- `S_IDLE`:
  - `E0` goes to `S_E0`.
  - `F0` goes to `S_F0`.
  - `FA` (ack) and `AA` (BAT pass) are dropped: no event, stay in `S_IDLE`.
  - Any other byte emits a make (ext=0, rel=0) and stays in `S_IDLE`.
- `S_E0`:
  - `F0` goes to `S_E0F0`.
  - `E0` raises `seq_error` and goes to `S_IDLE`.
  - Any other byte emits a make (ext=1) and goes to `S_IDLE`.
- `S_F0`:
  - `E0` or `F0` raises `seq_error` and goes to `S_IDLE`; no event.
  - Any other byte emits a break (ext=0, rel=1) and goes to `S_IDLE`.
- `S_E0F0`:
  - `E0` or `F0` raises `seq_error` and goes to `S_IDLE`; no event.
  - Any other byte emits a break (ext=1, rel=1) and goes to `S_IDLE`.
- Emit: `key_event` pulses, and `key_code`, `key_extended` and `key_release` load on the same edge.
- Held tracking, non-extended codes only:
  - A make of `ACCEL_CODE` sets `accel_held`; a break of `ACCEL_CODE` clears it.
  - `BRAKE_CODE` sets and clears `brake_held` the same way.
  - Extended codes with the same final byte (e.g. `E0 72`, down arrow) do not affect the held bits.
- Typematic repeats (repeated makes while a key is held) each produce a `key_event`. A repeat leaves an already-set held bit set.
- A break for a key that is not held produces a `key_event`; the held bit stays 0.
- Both keys held gives `accel`=2'b00. `accel` is combinational from the two held registers.
- Timeout:
  - A counter clears on every `received_data_en` and while in `S_IDLE`, and counts otherwise.
  - When the counter reaches `TIMEOUT_CYCLES-1` outside `S_IDLE`, the FSM returns to `S_IDLE` and `seq_error` pulses.
  - Counter width is `$clog2(TIMEOUT_CYCLES)`. The counter saturates and never wraps.
- Simultaneous `received_data_en` and timeout expiry: the byte wins. It is processed normally and no `seq_error` is raised.

## Timing
- Reset (asynchronous):
  - FSM goes to `S_IDLE` and the counter clears.
  - `key_event`, `key_code`, `key_extended`, `key_release`, `accel_held`, `brake_held` and `seq_error` all go to 0, so `accel`=2'b00.
  - A partial sequence interrupted by reset is discarded.
- Latency: the completing byte's strobe at edge N gives `key_event`=1 and updated held bits/`accel` after edge N+1, held for exactly one cycle.
- Back-to-back strobes on consecutive cycles are each processed; no byte is dropped.
- `seq_error` and `key_event` are never asserted in the same cycle.

## Test plan
- Reset, then send `73`: `key_event` pulses once with `key_code`=8'h73, ext=0, rel=0; `accel_held`=1 and `accel`=2'b10 from the next cycle.
- Send `F0 73`: `key_event` with rel=1; `accel_held`=0 and `accel`=2'b00. Then send `72`, `F0 72`: `accel` goes 2'b01, then 2'b00.
- Hold both keys (`73`, `72`): `accel`=2'b00. Then send `F0 72`: `accel`=2'b10.
- Send `E0 72`, then `E0 F0 72`: two events with ext=1 and rel=0, then rel=1; `brake_held` stays 0 throughout.
- Send `F0` then wait `TIMEOUT_CYCLES` with no bytes: `seq_error` pulses once and the FSM is in `S_IDLE`. A following `73` is a make. Repeat with the byte arriving on the expiry cycle: no error, and the byte is decoded as a break.
- Send `E0` then `E0`: `seq_error` pulses, no event. Separately, send `FA`: nothing happens. Separately, assert `reset` between `F0` and `73`: `73` decodes as a make.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder.
// Turns the raw byte stream from PS2_Controller into one registered event per
// complete make/break code (E0 extended and F0 break prefixes), and tracks
// whether the accelerate and brake keys are currently held down.
module ps2_scancode_decoder #(
    parameter logic [7:0] ACCEL_CODE     = 8'h73,
    parameter logic [7:0] BRAKE_CODE     = 8'h72,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       accel_held,
    output logic       brake_held,
    output logic [1:0] accel,
    output logic       seq_error
);

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_FA = 8'hFA;
    localparam logic [7:0] B_AA = 8'hAA;
    localparam int         CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] idle_cnt;
    logic             timeout;
    logic             dec_emit;
    logic             dec_err;
    logic             dec_ext;
    logic             dec_rel;

    // Prefix aborted when the keyboard goes quiet for too long mid-sequence.
    assign timeout = (state != S_IDLE) && (idle_cnt == CNT_LAST);

    // What the current byte means given the prefixes already seen.
    always_comb begin
        nxt_state = state;
        dec_emit  = 1'b0;
        dec_err   = 1'b0;
        dec_ext   = 1'b0;
        dec_rel   = 1'b0;
        case (state)
            S_IDLE: begin
                if (received_data == B_E0)
                    nxt_state = S_E0;
                else if (received_data == B_F0)
                    nxt_state = S_F0;
                else if (received_data != B_FA && received_data != B_AA)
                    dec_emit = 1'b1;   // ack / BAT-pass bytes are not keys
            end
            S_E0: begin
                if (received_data == B_F0) begin
                    nxt_state = S_E0F0;
                end else begin
                    nxt_state = S_IDLE;
                    if (received_data == B_E0) begin
                        dec_err = 1'b1;
                    end else begin
                        dec_emit = 1'b1;
                        dec_ext  = 1'b1;
                    end
                end
            end
            S_F0, S_E0F0: begin
                nxt_state = S_IDLE;
                if (received_data == B_E0 || received_data == B_F0) begin
                    dec_err = 1'b1;
                end else begin
                    dec_emit = 1'b1;
                    dec_rel  = 1'b1;
                    dec_ext  = (state == S_E0F0);
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Sequence FSM with registered event, key info and held-key tracking.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            key_event    <= 1'b0;
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_release  <= 1'b0;
            accel_held   <= 1'b0;
            brake_held   <= 1'b0;
            seq_error    <= 1'b0;
        end else begin
            key_event <= 1'b0;
            seq_error <= 1'b0;
            if (received_data_en) begin
                // A byte on the expiry cycle takes priority over the timeout.
                state     <= nxt_state;
                seq_error <= dec_err;
                if (dec_emit) begin
                    key_event    <= 1'b1;
                    key_code     <= received_data;
                    key_extended <= dec_ext;
                    key_release  <= dec_rel;
                    // Extended codes share final bytes with the tracked keys
                    // (E0 72 is down-arrow) and must not touch the held bits.
                    if (!dec_ext) begin
                        if (received_data == ACCEL_CODE)
                            accel_held <= !dec_rel;
                        if (received_data == BRAKE_CODE)
                            brake_held <= !dec_rel;
                    end
                end
            end else if (timeout) begin
                state     <= S_IDLE;
                seq_error <= 1'b1;
            end
        end
    end

    // Idle-cycle counter: runs only while a prefix is pending, saturates.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (received_data_en || state == S_IDLE)
            idle_cnt <= '0;
        else if (idle_cnt != '1)
            idle_cnt <= idle_cnt + 1'b1;
    end

    // Drive direction only when exactly one of the two keys is down.
    always_comb begin
        accel = 2'b00;
        if (accel_held && !brake_held)
            accel = 2'b10;
        else if (brake_held && !accel_held)
            accel = 2'b01;
    end

endmodule
